// File: rtl/jacobi_result_sink.sv
// Result-frame receiver for the Jacobi solver: buffers one stream frame, checks its length, holds it for host readout.
// Optional mid-frame stall detection is compiled in with `define JACOBI_SINK_TIMEOUT_EN.
`ifndef AXI4_FIFO_WORD_WIDTH
`define AXI4_FIFO_WORD_WIDTH 32
`endif

module jacobi_result_sink #(
    parameter int WORD_WIDTH     = `AXI4_FIFO_WORD_WIDTH,
    parameter int FRAME_WORDS    = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_dat_i,
    input  logic                  in_vld_i,
    input  logic                  in_last_i,
    output logic                  in_rdy_o,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WORD_WIDTH-1:0] rd_dat_o,
    output logic                  frame_done_o,
    output logic [ADDR_WIDTH:0]   frame_len_o,
    output logic                  err_short_o,
    output logic                  err_long_o,
    output logic                  err_timeout_o,
    input  logic                  done_ack_i
);

    localparam logic [ADDR_WIDTH:0] FW_W     = (ADDR_WIDTH+1)'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, HOLD} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   count, count_nxt, len_nxt;
    logic                  short_nxt, long_nxt, tmo_q, tmo_nxt;
    logic                  rdy_nxt, wr_en, accept, idle_expired, receiving;
    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    assign accept        = in_vld_i && in_rdy_o;
    assign receiving     = (state == RECV) || (state == DRAIN);
    assign err_timeout_o = tmo_q;

`ifdef JACOBI_SINK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;

    // Idle time only counts once a frame has started; any accepted beat restarts it.
    assign idle_expired = receiving && (count != '0) && !accept &&
                          (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (accept || !receiving || count == '0)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign idle_expired       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        len_nxt   = frame_len_o;
        short_nxt = err_short_o;
        long_nxt  = err_long_o;
        tmo_nxt   = tmo_q;
        wr_en     = 1'b0;
        case (state)
            IDLE: state_nxt = RECV;
            RECV: begin
                if (accept) begin
                    wr_en     = 1'b1;
                    count_nxt = count + 1'b1;
                    if (in_last_i) begin
                        state_nxt = HOLD;
                        len_nxt   = count + 1'b1;
                        short_nxt = (count + 1'b1) < FW_W;
                    end else if (count == LAST_IDX) begin
                        state_nxt = DRAIN;
                        long_nxt  = 1'b1;
                    end
                end else if (idle_expired) begin
                    state_nxt = HOLD;
                    len_nxt   = count;
                    tmo_nxt   = 1'b1;
                end
            end
            DRAIN: begin
                // Overlong tail is consumed so the upstream can finish its frame.
                if (accept && in_last_i) begin
                    state_nxt = HOLD;
                    len_nxt   = FW_W;
                end else if (idle_expired) begin
                    state_nxt = HOLD;
                    len_nxt   = count;
                    tmo_nxt   = 1'b1;
                end
            end
            HOLD: begin
                if (done_ack_i) begin
                    state_nxt = RECV;
                    count_nxt = '0;
                    len_nxt   = '0;
                    short_nxt = 1'b0;
                    long_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Leaving IDLE does not open the stream yet, so ready first rises one edge later.
        rdy_nxt = ((state_nxt == RECV) || (state_nxt == DRAIN)) && (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            frame_len_o  <= '0;
            err_short_o  <= 1'b0;
            err_long_o   <= 1'b0;
            tmo_q        <= 1'b0;
            in_rdy_o     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            frame_len_o  <= len_nxt;
            err_short_o  <= short_nxt;
            err_long_o   <= long_nxt;
            tmo_q        <= tmo_nxt;
            in_rdy_o     <= rdy_nxt;
            frame_done_o <= (state_nxt == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[count[ADDR_WIDTH-1:0]] <= in_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_dat_o <= '0;
        else if (rd_en_i)
            rd_dat_o <= mem[rd_addr_i];
    end

endmodule

// File: tb/tb_jacobi_result_sink.sv
// Directed/randomized bench for jacobi_result_sink against a frame-level length/content model.
// Exercises the stall timeout too when built with `define JACOBI_SINK_TIMEOUT_EN.
module tb_jacobi_result_sink;

    localparam int W  = 32;
    localparam int FW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_dat = '0;
    logic          in_vld = 1'b0;
    logic          in_last = 1'b0;
    logic          in_rdy;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_dat;
    logic          frame_done;
    logic [AW:0]   frame_len;
    logic          err_short, err_long, err_timeout;
    logic          done_ack = 1'b0;

    int passed = 0;
    int total  = 0;
    logic [W-1:0] sent [32];

    jacobi_result_sink #(
        .WORD_WIDTH(W), .FRAME_WORDS(FW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_dat_i(in_dat), .in_vld_i(in_vld), .in_last_i(in_last), .in_rdy_o(in_rdy),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_dat_o(rd_dat),
        .frame_done_o(frame_done), .frame_len_o(frame_len),
        .err_short_o(err_short), .err_long_o(err_long), .err_timeout_o(err_timeout),
        .done_ack_i(done_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) sent[i] = $urandom;
    endtask

    // Offers sent[0..n-1]; a beat counts as accepted when valid and ready are both high at the edge.
    task automatic send_frame(input string tag, input int n, input bit gaps, input bit use_last);
        int acc_cnt = 0;
        int budget = 0;
        bit acc;
        while (acc_cnt < n && budget < 2000) begin
            @(negedge clk);
            in_vld  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_dat  = sent[acc_cnt];
            in_last = use_last && (acc_cnt == n - 1);
            acc = in_vld && in_rdy;
            @(posedge clk);
            if (acc) acc_cnt++;
            budget++;
        end
        @(negedge clk);
        in_vld  = 1'b0;
        in_last = 1'b0;
        chk({tag, "_beats_accepted"}, acc_cnt, n);
    endtask

    task automatic read_check(input string tag, input int addr, input logic [W-1:0] exp);
        @(negedge clk);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        @(negedge clk);
        rd_en = 1'b0;
        chk(tag, rd_dat, exp);
    endtask

    // Expected outcome of a frame whose last flag came on beat n.
    task automatic check_frame(input string tag, input int n);
        int exp_len = (n > FW) ? FW : n;
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_rdy_low"}, in_rdy, 0);
        chk({tag, "_len"}, frame_len, exp_len);
        chk({tag, "_short"}, err_short, n < FW);
        chk({tag, "_long"}, err_long, n > FW);
        chk({tag, "_timeout"}, err_timeout, 0);
        for (int i = 0; i < exp_len; i++)
            read_check({tag, "_rd"}, i, sent[i]);
    endtask

    task automatic ack_and_check(input string tag);
        @(negedge clk);
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        chk({tag, "_ack_rdy"}, in_rdy, 1);
        chk({tag, "_ack_done"}, frame_done, 0);
        chk({tag, "_ack_len"}, frame_len, 0);
        chk({tag, "_ack_flags"}, {err_short, err_long, err_timeout}, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rdy", in_rdy, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_len", frame_len, 0);
        chk("reset_flags", {err_short, err_long, err_timeout}, 0);
        chk("reset_rd_dat", rd_dat, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_edge1", in_rdy, 0);
        @(negedge clk);
        chk("rdy_after_edge2", in_rdy, 1);

        // Nominal frame 0x1..0x10, continuous valid
        for (int i = 0; i < FW; i++) sent[i] = W'(i + 1);
        send_frame("nominal", FW, 1'b0, 1'b1);
        check_frame("nominal", FW);
        chk("rd_hold", rd_dat, sent[FW-1]);
        @(negedge clk);
        chk("rd_hold_2", rd_dat, sent[FW-1]);

        // Stream offered while a frame is held must stall
        in_vld = 1'b1;
        in_dat = 32'hdead_beef;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_stall_rdy", in_rdy, 0);
            chk("hold_stall_done", frame_done, 1);
        end
        in_vld = 1'b0;
        ack_and_check("nominal");

        // Short frame with valid gaps
        fill_random(10);
        send_frame("short", 10, 1'b1, 1'b1);
        check_frame("short", 10);
        ack_and_check("short");

        // Overlong frame: tail is accepted and dropped
        fill_random(20);
        send_frame("long", 20, 1'b1, 1'b1);
        check_frame("long", 20);
        ack_and_check("long");

        // Reset in the middle of a frame
        fill_random(7);
        send_frame("partial", 7, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rdy", in_rdy, 0);
        chk("midrst_done", frame_done, 0);
        chk("midrst_len", frame_len, 0);
        chk("midrst_flags", {err_short, err_long, err_timeout}, 0);
        chk("midrst_rd_dat", rd_dat, 0);
        @(negedge clk);
        rst = 1'b0;
        fill_random(FW);
        send_frame("after_rst", FW, 1'b1, 1'b1);
        check_frame("after_rst", FW);
        ack_and_check("after_rst");

`ifdef JACOBI_SINK_TIMEOUT_EN
        // Five beats then silence: held after eight idle cycles
        fill_random(5);
        send_frame("stall", 5, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        chk("stall_done_early", frame_done, 0);
        @(negedge clk);
        chk("stall_done", frame_done, 1);
        chk("stall_timeout", err_timeout, 1);
        chk("stall_len", frame_len, 5);
        chk("stall_rdy", in_rdy, 0);
        for (int i = 0; i < 5; i++)
            read_check("stall_rd", i, sent[i]);
        ack_and_check("stall");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
